// File: rtl/el2_banked_mem_2port.sv
// Banked, word-interleaved two-port SRAM for DCCM-style use. Every bank is cleared
// after reset, port 0 wins same-bank conflicts, and read data returns after RD_LATENCY cycles.
module el2_banked_mem_2port #(
    parameter int unsigned NUM_BANKS  = 4,
    parameter int unsigned DEPTH      = 512,
    parameter int unsigned WIDTH      = 39,
    parameter int unsigned RD_LATENCY = 1,
    parameter logic [WIDTH-1:0] INIT_VALUE = '0,
    localparam int unsigned BB = $clog2(NUM_BANKS),
    localparam int unsigned IB = $clog2(DEPTH),
    localparam int unsigned AW = BB + IB
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             p0_valid,
    output logic             p0_ready,
    input  logic             p0_we,
    input  logic [AW-1:0]    p0_addr,
    input  logic [WIDTH-1:0] p0_wdata,
    output logic             p0_rvalid,
    output logic [WIDTH-1:0] p0_rdata,
    input  logic             p1_valid,
    output logic             p1_ready,
    input  logic             p1_we,
    input  logic [AW-1:0]    p1_addr,
    input  logic [WIDTH-1:0] p1_wdata,
    output logic             p1_rvalid,
    output logic [WIDTH-1:0] p1_rdata,
    output logic             init_done,
    output logic [15:0]      conflict_cnt
);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]       state;
    logic [IB-1:0]    init_idx;
    logic [WIDTH-1:0] mem [NUM_BANKS][DEPTH];

    logic [BB-1:0]    p0_bank, p1_bank;
    logic [IB-1:0]    p0_idx, p1_idx;
    logic             run, bank_conflict, p0_acc, p1_acc;
    logic [1:0]       rd_acc;
    logic [WIDTH-1:0] rd_word [2];

    // First pipeline stage: one registered read word per port
    logic [1:0]       s1_valid;
    logic [WIDTH-1:0] s1_data [2];

    assign p0_bank = p0_addr[BB-1:0];
    assign p0_idx  = p0_addr[AW-1:BB];
    assign p1_bank = p1_addr[BB-1:0];
    assign p1_idx  = p1_addr[AW-1:BB];

    assign run           = (state == ST_RUN);
    assign bank_conflict = p0_valid & p1_valid & (p0_bank == p1_bank);
    assign p0_ready      = run;
    assign p1_ready      = run & ~bank_conflict;
    assign p0_acc        = p0_valid & p0_ready;
    assign p1_acc        = p1_valid & p1_ready;
    assign init_done     = run;

    assign rd_acc[0]  = p0_acc & ~p0_we;
    assign rd_acc[1]  = p1_acc & ~p1_we;
    assign rd_word[0] = mem[p0_bank][p0_idx];
    assign rd_word[1] = mem[p1_bank][p1_idx];

    // Init sweep counter and INIT -> RUN transition
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_INIT;
            init_idx <= '0;
        end else if (state == ST_INIT) begin
            init_idx <= init_idx + 1'b1;
            if (init_idx == IB'(DEPTH - 1)) begin
                state <= ST_RUN;
            end
        end
    end

    // Array writes: init sweep clears one row across all banks, then accepted port writes
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == ST_INIT) begin
                for (int b = 0; b < NUM_BANKS; b++) begin
                    mem[b][init_idx] <= INIT_VALUE;
                end
            end else begin
                if (p0_acc && p0_we) mem[p0_bank][p0_idx] <= p0_wdata;
                if (p1_acc && p1_we) mem[p1_bank][p1_idx] <= p1_wdata;
            end
        end
    end

    // Saturating count of cycles where port 1 is stalled by port 0
    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_cnt <= '0;
        end else if (run && bank_conflict && (conflict_cnt != 16'hFFFF)) begin
            conflict_cnt <= conflict_cnt + 16'd1;
        end
    end

    // Read stage 1: data register only loads on an accepted read so rdata holds otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= '0;
            for (int p = 0; p < 2; p++) s1_data[p] <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                s1_valid[p] <= rd_acc[p];
                if (rd_acc[p]) s1_data[p] <= rd_word[p];
            end
        end
    end

    if (RD_LATENCY == 2) begin : g_lat2
        logic [1:0]       s2_valid;
        logic [WIDTH-1:0] s2_data [2];

        // Read stage 2: extra output register, also hold-on-idle
        always_ff @(posedge clk) begin
            if (rst) begin
                s2_valid <= '0;
                for (int p = 0; p < 2; p++) s2_data[p] <= '0;
            end else begin
                for (int p = 0; p < 2; p++) begin
                    s2_valid[p] <= s1_valid[p];
                    if (s1_valid[p]) s2_data[p] <= s1_data[p];
                end
            end
        end

        assign p0_rvalid = s2_valid[0];
        assign p1_rvalid = s2_valid[1];
        assign p0_rdata  = s2_data[0];
        assign p1_rdata  = s2_data[1];
    end else begin : g_lat1
        assign p0_rvalid = s1_valid[0];
        assign p1_rvalid = s1_valid[1];
        assign p0_rdata  = s1_data[0];
        assign p1_rdata  = s1_data[1];
    end

endmodule

// File: tb/tb_el2_banked_mem_2port.sv
// Bench for el2_banked_mem_2port: two instances (4 banks/latency 1 and 8 banks/latency 2)
// share stimulus; the selected one is checked against a flat word-addressed memory model.
module tb_el2_banked_mem_2port;

    localparam int W = 39;
    localparam int D = 512;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          v0 = 0, we0 = 0, v1 = 0, we1 = 0;
    logic [11:0]   a0 = '0, a1 = '0;
    logic [W-1:0]  d0 = '0, d1 = '0;

    logic          u0_r0, u0_r1, u0_rv0, u0_rv1, u0_done;
    logic [W-1:0]  u0_rd0, u0_rd1;
    logic [15:0]   u0_cnt;
    logic          u1_r0, u1_r1, u1_rv0, u1_rv1, u1_done;
    logic [W-1:0]  u1_rd0, u1_rd1;
    logic [15:0]   u1_cnt;

    el2_banked_mem_2port #(
        .NUM_BANKS(4), .DEPTH(D), .WIDTH(W), .RD_LATENCY(1), .INIT_VALUE(39'h0)
    ) u0 (
        .clk(clk), .rst(rst),
        .p0_valid(v0), .p0_ready(u0_r0), .p0_we(we0), .p0_addr(a0[10:0]), .p0_wdata(d0),
        .p0_rvalid(u0_rv0), .p0_rdata(u0_rd0),
        .p1_valid(v1), .p1_ready(u0_r1), .p1_we(we1), .p1_addr(a1[10:0]), .p1_wdata(d1),
        .p1_rvalid(u0_rv1), .p1_rdata(u0_rd1),
        .init_done(u0_done), .conflict_cnt(u0_cnt)
    );

    el2_banked_mem_2port #(
        .NUM_BANKS(8), .DEPTH(D), .WIDTH(W), .RD_LATENCY(2), .INIT_VALUE(39'h0)
    ) u1 (
        .clk(clk), .rst(rst),
        .p0_valid(v0), .p0_ready(u1_r0), .p0_we(we0), .p0_addr(a0), .p0_wdata(d0),
        .p0_rvalid(u1_rv0), .p0_rdata(u1_rd0),
        .p1_valid(v1), .p1_ready(u1_r1), .p1_we(we1), .p1_addr(a1), .p1_wdata(d1),
        .p1_rvalid(u1_rv1), .p1_rdata(u1_rd1),
        .init_done(u1_done), .conflict_cnt(u1_cnt)
    );

    logic          sel = 1'b0;
    logic          s_r0, s_r1, s_rv0, s_rv1, s_done;
    logic [W-1:0]  s_rd0, s_rd1;
    logic [15:0]   s_cnt;
    assign s_r0   = sel ? u1_r0   : u0_r0;
    assign s_r1   = sel ? u1_r1   : u0_r1;
    assign s_rv0  = sel ? u1_rv0  : u0_rv0;
    assign s_rv1  = sel ? u1_rv1  : u0_rv1;
    assign s_rd0  = sel ? u1_rd0  : u0_rd0;
    assign s_rd1  = sel ? u1_rd1  : u0_rd1;
    assign s_done = sel ? u1_done : u0_done;
    assign s_cnt  = sel ? u1_cnt  : u0_cnt;

    // Reference model: flat memory, list of outstanding reads with due cycle
    typedef struct {
        int           due;
        logic [W-1:0] data;
    } rd_t;

    int           cur_nb, cur_lat;
    logic [W-1:0] mdl_mem [4096];
    rd_t          q0[$], q1[$];
    logic [W-1:0] last0, last1;
    int           n_since, mdl_cnt;
    int           rv_seen0, rv_seen1;
    bit           last_acc1;
    int           tests = 0, fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s (cfg %0d): got %0h expected %0h", name, sel, act, exp);
        end
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        last0 = '0;
        last1 = '0;
        n_since = 0;
        mdl_cnt = 0;
        for (int i = 0; i < 4096; i++) mdl_mem[i] = '0;
    endtask

    task automatic drive(input logic iv0, input logic iwe0, input int ia0, input logic [W-1:0] id0,
                         input logic iv1, input logic iwe1, input int ia1,
                         input logic [W-1:0] id1);
        v0 = iv0; we0 = iwe0; a0 = 12'(ia0); d0 = id0;
        v1 = iv1; we1 = iwe1; a1 = 12'(ia1); d1 = id1;
    endtask

    task automatic idle();
        drive(0, 0, 0, '0, 0, 0, 0, '0);
    endtask

    // One clock: check outputs at negedge against the model, then advance the model at posedge
    task automatic cycle();
        bit mr, conf, acc0, acc1, e0, e1;
        @(negedge clk);
        mr   = (n_since >= D);
        conf = v0 && v1 && ((int'(a0) % cur_nb) == (int'(a1) % cur_nb));
        chk("init_done", s_done, mr);
        chk("p0_ready", s_r0, mr);
        chk("p1_ready", s_r1, mr && !conf);
        e0 = (q0.size() > 0) && (q0[0].due == n_since);
        e1 = (q1.size() > 0) && (q1[0].due == n_since);
        if (e0) begin last0 = q0[0].data; void'(q0.pop_front()); end
        if (e1) begin last1 = q1[0].data; void'(q1.pop_front()); end
        chk("p0_rvalid", s_rv0, e0);
        chk("p1_rvalid", s_rv1, e1);
        chk("p0_rdata", s_rd0, last0);
        chk("p1_rdata", s_rd1, last1);
        chk("conflict_cnt", s_cnt, mdl_cnt);
        if (s_rv0) rv_seen0++;
        if (s_rv1) rv_seen1++;
        acc0 = mr && v0;
        acc1 = mr && v1 && !conf;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            n_since++;
            if (acc0 && !we0) q0.push_back('{due: n_since + cur_lat - 1, data: mdl_mem[a0]});
            if (acc1 && !we1) q1.push_back('{due: n_since + cur_lat - 1, data: mdl_mem[a1]});
            if (acc0 && we0) mdl_mem[a0] = d0;
            if (acc1 && we1) mdl_mem[a1] = d1;
            if (mr && conf && mdl_cnt < 65535) mdl_cnt++;
        end
        last_acc1 = acc1;
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        @(posedge clk);
        model_reset();
        #1;
        rst = 1'b0;
    endtask

    // Runs idle cycles until init_done, returns how many cycles init_done stayed low
    task automatic wait_init(output int k);
        k = 0;
        idle();
        while (!s_done && k < 600) begin
            k++;
            cycle();
        end
    endtask

    typedef struct {
        logic v0, we0;
        int   a0;
        logic v1, we1;
        int   a1;
        logic r1_nb4, r1_nb8;
    } vec_t;

    task automatic run_suite();
        vec_t tbl[8];
        int   k, c0, r0s, r1s;
        tbl[0] = '{1, 0, 0,  1, 0, 4,  0, 1};
        tbl[1] = '{1, 0, 1,  1, 0, 9,  0, 0};
        tbl[2] = '{1, 1, 3,  1, 0, 5,  1, 1};
        tbl[3] = '{0, 0, 0,  1, 0, 2,  1, 1};
        tbl[4] = '{1, 1, 6,  1, 1, 14, 0, 0};
        tbl[5] = '{1, 0, 16, 1, 1, 20, 0, 1};
        tbl[6] = '{1, 1, 7,  0, 0, 7,  1, 1};
        tbl[7] = '{1, 0, 7,  1, 0, 8,  1, 1};

        // Init sweep length and cleared contents
        do_reset();
        chk("reset_done", s_done, 0);
        chk("reset_cnt", s_cnt, 0);
        wait_init(k);
        chk("init_len", k, D);
        drive(1, 0, 'h1A5, '0, 0, 0, 0, '0);
        cycle();
        idle();
        repeat (cur_lat) cycle();
        chk("init_word", s_rd0, 0);

        // Table of port-1 arbitration outcomes
        foreach (tbl[i]) begin
            drive(tbl[i].v0, tbl[i].we0, tbl[i].a0, W'({$urandom(), $urandom()}),
                  tbl[i].v1, tbl[i].we1, tbl[i].a1, W'({$urandom(), $urandom()}));
            #1;
            chk("tbl_p1_ready", s_r1, (cur_nb == 8) ? tbl[i].r1_nb8 : tbl[i].r1_nb4);
            cycle();
        end
        idle();
        repeat (3) cycle();

        // Write on p0 then read on p1 next cycle
        r1s = rv_seen1;
        drive(1, 1, 5, 39'h7F00, 0, 0, 0, '0);
        cycle();
        drive(0, 0, 0, '0, 1, 0, 5, '0);
        cycle();
        idle();
        repeat (cur_lat) cycle();
        chk("raw_rdata", s_rd1, 39'h7F00);
        chk("raw_rvalid_count", rv_seen1 - r1s, 1);

        // Same-bank conflict, then p1 retried alone
        c0 = mdl_cnt;
        drive(1, 0, cur_nb, '0, 1, 0, 2 * cur_nb, '0);
        cycle();
        chk("conflict_cnt_inc", s_cnt, c0 + 1);
        drive(0, 0, 0, '0, 1, 0, 2 * cur_nb, '0);
        cycle();
        idle();
        repeat (cur_lat + 1) cycle();

        // Streaming reads on different banks
        drive(1, 1, 1, 39'h1_2345_6789, 1, 1, 2, 39'h7E_DCBA_9876);
        cycle();
        c0 = mdl_cnt;
        r0s = rv_seen0;
        r1s = rv_seen1;
        drive(1, 0, 1, '0, 1, 0, 2, '0);
        repeat (100) cycle();
        idle();
        repeat (cur_lat) cycle();
        chk("stream_rv0", rv_seen0 - r0s, 100);
        chk("stream_rv1", rv_seen1 - r1s, 100);
        chk("stream_cnt", s_cnt, c0);

        // Random traffic on a few banks; p1 holds its request while stalled
        last_acc1 = 1;
        for (int i = 0; i < 400; i++) begin
            v0 = 1'($urandom_range(0, 1));
            we0 = 1'($urandom_range(0, 1));
            a0 = 12'($urandom_range(0, 63));
            d0 = W'({$urandom(), $urandom()});
            if (!(v1 && !last_acc1)) begin
                v1 = 1'($urandom_range(0, 1));
                we1 = 1'($urandom_range(0, 1));
                a1 = 12'($urandom_range(0, 63));
                d1 = W'({$urandom(), $urandom()});
            end
            cycle();
        end
        idle();
        repeat (3) cycle();

        // Reset right after a read is accepted; init restarts and clears the word
        drive(1, 1, 7, 39'h55, 0, 0, 0, '0);
        cycle();
        drive(1, 0, 7, '0, 0, 0, 0, '0);
        cycle();
        idle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        r0s = rv_seen0;
        wait_init(k);
        chk("reinit_len", k, D);
        chk("reset_drop_rvalid", rv_seen0 - r0s, 0);
        drive(1, 0, 7, '0, 0, 0, 0, '0);
        cycle();
        idle();
        repeat (cur_lat) cycle();
        chk("reinit_rvalid", rv_seen0 - r0s, 1);
        chk("reinit_word", s_rd0, 0);
    endtask

    initial begin
        rv_seen0 = 0;
        rv_seen1 = 0;
        model_reset();

        sel = 1'b0;
        cur_nb = 4;
        cur_lat = 1;
        run_suite();

        // Saturation of the conflict counter
        drive(1, 0, 0, '0, 1, 0, 4, '0);
        repeat (70000) @(posedge clk);
        #1;
        chk("cnt_saturate", s_cnt, 16'hFFFF);
        repeat (5) @(posedge clk);
        #1;
        chk("cnt_no_wrap", s_cnt, 16'hFFFF);

        sel = 1'b1;
        cur_nb = 8;
        cur_lat = 2;
        run_suite();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
